// File: rtl/mps_op_cmd_arbiter.sv
// mps_op_cmd_arbiter: command sequencer in front of the MPS operation FSM.
// Merges PS register and debounced front-panel on/off requests, issues
// single-cycle on/off flags, tracks on/off state codes for completion and
// failure, applies bounded auto-retry and latches a lockout.
//
// Ports:
//   i_clk, i_rst              clock, async active-high reset
//   i_remote_mode             1 = PS on commands, 0 = front-panel on commands
//   i_ps_on_cmd/i_ps_off_cmd  register-interface request pulses
//   i_fp_on_btn/i_fp_off_btn  raw front-panel button levels
//   i_intl, i_intl_clr        interlock level, lockout release pulse
//   i_retry_en                enables auto-retry on failed on sequence
//   i_on_state, i_off_state   operation FSM state codes
//   o_op_on_flag/o_op_off_flag command pulses to operation FSM
//   o_cmd_ack/o_cmd_nack      accept/reject pulses for external requests
//   o_system_on, o_lockout    RUN / LOCKOUT indicators
//   o_retry_cnt               retries consumed by current on request
//   o_ctrl_state              sequencer state code

module mps_op_cmd_arbiter_db #(
    parameter int DB_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic rise
);
    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    logic          s1;
    logic          s2;
    logic          lvl;
    logic          lvl_d;
    logic [CW-1:0] cnt;

    // Counter runs only while the synchronized level disagrees with the
    // accepted level; any return to agreement (a bounce) restarts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            lvl   <= 1'b0;
            lvl_d <= 1'b0;
            cnt   <= '0;
        end else begin
            s1    <= btn;
            s2    <= s1;
            lvl_d <= lvl;
            if (s2 == lvl) begin
                cnt <= '0;
            end else if (cnt == CW'(DB_CYCLES - 1)) begin
                lvl <= s2;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign rise = lvl & ~lvl_d;
endmodule

module mps_op_cmd_arbiter #(
    parameter int DB_CYCLES = 100000,
    parameter int RETRY_DLY = 10000000,
    parameter int MAX_RETRY = 2,
    parameter int START_TO  = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_remote_mode,
    input  logic       i_ps_on_cmd,
    input  logic       i_ps_off_cmd,
    input  logic       i_fp_on_btn,
    input  logic       i_fp_off_btn,
    input  logic       i_intl,
    input  logic       i_intl_clr,
    input  logic       i_retry_en,
    input  logic [3:0] i_on_state,
    input  logic [3:0] i_off_state,
    output logic       o_op_on_flag,
    output logic       o_op_off_flag,
    output logic       o_cmd_ack,
    output logic       o_cmd_nack,
    output logic       o_system_on,
    output logic       o_lockout,
    output logic [3:0] o_retry_cnt,
    output logic [2:0] o_ctrl_state
);
    localparam int TMAX = (RETRY_DLY > START_TO) ? RETRY_DLY : START_TO;
    localparam int TW   = $clog2(TMAX + 2);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_ISSUE_ON   = 3'd1,
        S_WAIT_ON    = 3'd2,
        S_RUN        = 3'd3,
        S_ISSUE_OFF  = 3'd4,
        S_WAIT_OFF   = 3'd5,
        S_RETRY_WAIT = 3'd6,
        S_LOCKOUT    = 3'd7
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [3:0]    on_q;
    logic [3:0]    off_q;
    logic [TW-1:0] timer;
    logic [3:0]    retry_cnt;
    logic [3:0]    retry_n;
    logic          ack_r;
    logic          ack_n;
    logic          nack_r;
    logic          nack_n;
    logic          lock_off_r;
    logic          lock_off_n;
    logic          fp_on_rise;
    logic          fp_off_rise;
    logic          on_req;
    logic          off_req;

    mps_op_cmd_arbiter_db #(.DB_CYCLES(DB_CYCLES)) u_db_on (
        .clk  (i_clk),
        .rst  (i_rst),
        .btn  (i_fp_on_btn),
        .rise (fp_on_rise)
    );

    mps_op_cmd_arbiter_db #(.DB_CYCLES(DB_CYCLES)) u_db_off (
        .clk  (i_clk),
        .rst  (i_rst),
        .btn  (i_fp_off_btn),
        .rise (fp_off_rise)
    );

    // On requests only from the enabled source; off from either.
    assign on_req  = i_remote_mode ? i_ps_on_cmd : fp_on_rise;
    assign off_req = i_ps_off_cmd | fp_off_rise;

    always_comb begin
        state_n    = state;
        retry_n    = retry_cnt;
        ack_n      = 1'b0;
        nack_n     = 1'b0;
        lock_off_n = 1'b0;
        if (i_intl && state != S_LOCKOUT) begin
            // Interlock wins, but an off request is still carried out.
            state_n = S_LOCKOUT;
            if (off_req) begin
                ack_n      = 1'b1;
                lock_off_n = 1'b1;
            end else if (on_req) begin
                nack_n = 1'b1;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (off_req) begin
                        state_n = S_ISSUE_OFF;
                        ack_n   = 1'b1;
                    end else if (on_req) begin
                        if (on_q == 4'd0 && off_q == 4'd0) begin
                            state_n = S_ISSUE_ON;
                            ack_n   = 1'b1;
                            retry_n = 4'd0;
                        end else begin
                            nack_n = 1'b1;
                        end
                    end
                end
                S_ISSUE_ON: begin
                    if (off_req) begin
                        state_n = S_ISSUE_OFF;
                        ack_n   = 1'b1;
                    end else begin
                        state_n = S_WAIT_ON;
                        nack_n  = on_req;
                    end
                end
                S_WAIT_ON: begin
                    if (off_req) begin
                        state_n = S_ISSUE_OFF;
                        ack_n   = 1'b1;
                    end else begin
                        nack_n = on_req;
                        if (on_q == 4'd14) begin
                            state_n = S_RUN;
                        end else if (on_q == 4'd15) begin
                            if (i_retry_en && retry_cnt < 4'(MAX_RETRY)) begin
                                state_n = S_RETRY_WAIT;
                                retry_n = retry_cnt + 4'd1;
                            end else begin
                                state_n = S_LOCKOUT;
                            end
                        end else if (on_q == 4'd0 && timer >= TW'(START_TO)) begin
                            state_n = S_IDLE;
                            nack_n  = 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (off_req) begin
                        state_n = S_ISSUE_OFF;
                        ack_n   = 1'b1;
                    end else begin
                        nack_n = on_req;
                        if (on_q == 4'd15) begin
                            state_n = S_LOCKOUT;
                        end else if (on_q == 4'd0) begin
                            state_n = S_IDLE;
                        end
                    end
                end
                S_ISSUE_OFF: begin
                    state_n = S_WAIT_OFF;
                    nack_n  = off_req | on_req;
                end
                S_WAIT_OFF: begin
                    nack_n = off_req | on_req;
                    if (off_q == 4'd3) begin
                        state_n = S_IDLE;
                    end
                end
                S_RETRY_WAIT: begin
                    if (off_req) begin
                        state_n = S_ISSUE_OFF;
                        ack_n   = 1'b1;
                    end else begin
                        nack_n = on_req;
                        if (timer >= TW'(RETRY_DLY - 1)) begin
                            state_n = S_ISSUE_ON;
                        end
                    end
                end
                S_LOCKOUT: begin
                    if (off_req) begin
                        ack_n      = 1'b1;
                        lock_off_n = 1'b1;
                    end else if (on_req) begin
                        nack_n = 1'b1;
                    end
                    if (i_intl_clr && !i_intl && on_q == 4'd0) begin
                        state_n = S_IDLE;
                        retry_n = 4'd0;
                    end
                end
                default: begin
                    state_n = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= S_IDLE;
            on_q       <= 4'd0;
            off_q      <= 4'd0;
            timer      <= '0;
            retry_cnt  <= 4'd0;
            ack_r      <= 1'b0;
            nack_r     <= 1'b0;
            lock_off_r <= 1'b0;
        end else begin
            state      <= state_n;
            on_q       <= i_on_state;
            off_q      <= i_off_state;
            retry_cnt  <= retry_n;
            ack_r      <= ack_n;
            nack_r     <= nack_n;
            lock_off_r <= lock_off_n;
            // Timer restarts on every state entry and saturates.
            if (state_n != state) begin
                timer <= '0;
            end else if (timer != '1) begin
                timer <= timer + 1'b1;
            end
        end
    end

    assign o_op_on_flag  = (state == S_ISSUE_ON);
    assign o_op_off_flag = (state == S_ISSUE_OFF) | lock_off_r;
    assign o_cmd_ack     = ack_r;
    assign o_cmd_nack    = nack_r;
    assign o_system_on   = (state == S_RUN);
    assign o_lockout     = (state == S_LOCKOUT);
    assign o_retry_cnt   = retry_cnt;
    assign o_ctrl_state  = state;
endmodule

// File: tb/tb_mps_op_cmd_arbiter.sv
// Directed testbench for mps_op_cmd_arbiter with small timing parameters.
// Inputs change on falling edges; outputs are checked on falling edges.

module tb_mps_op_cmd_arbiter;
    localparam int DB  = 8;
    localparam int RD  = 20;
    localparam int MR  = 2;
    localparam int STO = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       remote = 1'b0;
    logic       ps_on = 1'b0;
    logic       ps_off = 1'b0;
    logic       fp_on = 1'b0;
    logic       fp_off = 1'b0;
    logic       intl = 1'b0;
    logic       intl_clr = 1'b0;
    logic       retry_en = 1'b0;
    logic [3:0] on_state = 4'd0;
    logic [3:0] off_state = 4'd0;
    logic       on_flag;
    logic       off_flag;
    logic       ack;
    logic       nack;
    logic       sys_on;
    logic       lockout;
    logic [3:0] retry_cnt;
    logic [2:0] cstate;

    int total = 0;
    int bad = 0;

    mps_op_cmd_arbiter #(
        .DB_CYCLES (DB),
        .RETRY_DLY (RD),
        .MAX_RETRY (MR),
        .START_TO  (STO)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_remote_mode (remote),
        .i_ps_on_cmd   (ps_on),
        .i_ps_off_cmd  (ps_off),
        .i_fp_on_btn   (fp_on),
        .i_fp_off_btn  (fp_off),
        .i_intl        (intl),
        .i_intl_clr    (intl_clr),
        .i_retry_en    (retry_en),
        .i_on_state    (on_state),
        .i_off_state   (off_state),
        .o_op_on_flag  (on_flag),
        .o_op_off_flag (off_flag),
        .o_cmd_ack     (ack),
        .o_cmd_nack    (nack),
        .o_system_on   (sys_on),
        .o_lockout     (lockout),
        .o_retry_cnt   (retry_cnt),
        .o_ctrl_state  (cstate)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Pulse for one cycle; returns at the falling edge where the
    // response (cycle N+1) is visible.
    task automatic pulse(input bit on, input bit off, input bit clr);
        @(negedge clk);
        ps_on    = on;
        ps_off   = off;
        intl_clr = clr;
        @(negedge clk);
        ps_on    = 1'b0;
        ps_off   = 1'b0;
        intl_clr = 1'b0;
    endtask

    initial begin
        int n_on;
        int n_off;
        int n_ack;
        int n_nack;
        int since;
        int last;
        int gap1;
        int gap2;
        bit seen;

        // Reset
        repeat (3) @(negedge clk);
        chk("rst_state", 32'(cstate), 0);
        chk("rst_flags", {30'd0, on_flag, off_flag}, 0);
        chk("rst_acks", {30'd0, ack, nack}, 0);
        chk("rst_retry", 32'(retry_cnt), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Remote on
        remote = 1'b1;
        pulse(1, 0, 0);
        chk("on_issue_state", 32'(cstate), 1);
        chk("on_flag", 32'(on_flag), 1);
        chk("on_ack", 32'(ack), 1);
        @(negedge clk);
        chk("on_wait_state", 32'(cstate), 2);
        chk("on_flag_width", 32'(on_flag), 0);
        for (int v = 1; v <= 14; v++) begin
            on_state = 4'(v);
            @(negedge clk);
        end
        @(negedge clk);
        chk("run_state", 32'(cstate), 3);
        chk("run_sys_on", 32'(sys_on), 1);

        // Off from RUN via front-panel button (honoured in remote mode)
        n_off = 0;
        n_ack = 0;
        fp_off = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == DB + 5) fp_off = 1'b0;
            if (off_flag) n_off++;
            if (ack) n_ack++;
        end
        chk("fp_off_flags", 32'(n_off), 1);
        chk("fp_off_acks", 32'(n_ack), 1);
        chk("fp_off_wait", 32'(cstate), 5);
        off_state = 4'd1;
        on_state = 4'd0;
        @(negedge clk);
        off_state = 4'd2;
        @(negedge clk);
        off_state = 4'd3;
        @(negedge clk);
        off_state = 4'd0;
        @(negedge clk);
        chk("off_idle", 32'(cstate), 0);
        chk("off_sys_on", 32'(sys_on), 0);
        repeat (15) @(negedge clk);

        // Simultaneous on and off in IDLE
        pulse(1, 1, 0);
        chk("sim_state", 32'(cstate), 4);
        chk("sim_off_flag", 32'(off_flag), 1);
        chk("sim_on_flag", 32'(on_flag), 0);
        chk("sim_ack", 32'(ack), 1);
        chk("sim_nack", 32'(nack), 0);
        @(negedge clk);
        chk("sim_wait_off", 32'(cstate), 5);
        pulse(1, 0, 0);
        chk("woff_on_nack", 32'(nack), 1);
        chk("woff_on_noack", 32'(ack), 0);
        chk("woff_stay", 32'(cstate), 5);
        off_state = 4'd3;
        @(negedge clk);
        off_state = 4'd0;
        @(negedge clk);
        chk("woff_1cyc_idle", 32'(cstate), 0);

        // Start timeout: on_state never leaves 0
        pulse(1, 0, 0);
        chk("sto_issue", 32'(on_flag), 1);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (nack) seen = 1'b1;
        end
        chk("sto_nack", 32'(seen), 1);
        chk("sto_idle", 32'(cstate), 0);

        // Retry: every attempt fails with a one-cycle code 15
        retry_en = 1'b1;
        n_on = 0;
        n_ack = 0;
        since = 100;
        last = 0;
        gap1 = 0;
        gap2 = 0;
        @(negedge clk);
        ps_on = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            ps_on = 1'b0;
            if (lockout) break;
            if (ack) n_ack++;
            if (on_flag) begin
                n_on++;
                if (n_on == 2) gap1 = c - last;
                if (n_on == 3) gap2 = c - last;
                last = c;
                since = 0;
            end
            if (since == 2) on_state = 4'd15;
            else if (since == 3) on_state = 4'd0;
            since++;
        end
        chk("retry_flags", 32'(n_on), 3);
        chk("retry_acks", 32'(n_ack), 1);
        chk("retry_gap1", 32'(gap1), RD + 4);
        chk("retry_gap2", 32'(gap2), RD + 4);
        chk("retry_lockout", 32'(lockout), 1);
        chk("retry_cnt", 32'(retry_cnt), 2);
        pulse(0, 0, 1);
        chk("retry_clr_idle", 32'(cstate), 0);
        chk("retry_clr_cnt", 32'(retry_cnt), 0);
        retry_en = 1'b0;

        // Interlock in RUN
        pulse(1, 0, 0);
        on_state = 4'd14;
        repeat (3) @(negedge clk);
        chk("intl_run", 32'(cstate), 3);
        intl = 1'b1;
        @(negedge clk);
        chk("intl_lockout", 32'(cstate), 7);
        chk("intl_lock_out", 32'(lockout), 1);
        chk("intl_no_retry", 32'(retry_cnt), 0);
        on_state = 4'd0;
        @(negedge clk);
        pulse(0, 0, 1);
        chk("intl_clr_ignored", 32'(cstate), 7);
        pulse(0, 1, 0);
        chk("lock_off_flag", 32'(off_flag), 1);
        chk("lock_off_ack", 32'(ack), 1);
        chk("lock_off_stay", 32'(cstate), 7);
        @(negedge clk);
        chk("lock_off_width", 32'(off_flag), 0);
        pulse(1, 0, 0);
        chk("lock_on_nack", 32'(nack), 1);
        intl = 1'b0;
        repeat (2) @(negedge clk);
        pulse(0, 0, 1);
        chk("intl_clr_idle", 32'(cstate), 0);

        // Button bounce in local mode
        remote = 1'b0;
        n_on = 0;
        n_ack = 0;
        n_nack = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            fp_on = (i < 4) || (i >= 6 && i < 11) || (i >= 14 && i < 17);
            if (on_flag) n_on++;
            if (ack) n_ack++;
            if (nack) n_nack++;
        end
        chk("bounce_flags", 32'(n_on), 0);
        chk("bounce_acks", 32'(n_ack + n_nack), 0);
        pulse(1, 0, 0);
        chk("local_ps_ack", 32'(ack), 0);
        chk("local_ps_nack", 32'(nack), 0);
        chk("local_ps_state", 32'(cstate), 0);

        // Stable press in local mode, then reset mid-operation
        seen = 1'b0;
        fp_on = 1'b1;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (on_flag) seen = 1'b1;
        end
        chk("fp_on_flag", 32'(seen), 1);
        chk("fp_on_ack", 32'(ack), 1);
        fp_on = 1'b0;
        @(negedge clk);
        chk("fp_on_wait", 32'(cstate), 2);
        rst = 1'b1;
        #1;
        chk("midrst_state", 32'(cstate), 0);
        @(negedge clk);
        chk("midrst_flags", {30'd0, on_flag, off_flag}, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_idle", 32'(cstate), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
